// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port data memory arbiter: FSM states, port indices, memory rw codes.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_DMA  = 1'b1;

   localparam logic RW_WRITE  = 1'b0;
   localparam logic RW_READ   = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin pick: a lone request wins, a tie goes to the port that did not win last.
module rr_arbiter_2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_gnt_i,
   output logic       gnt_idx_o,
   output logic       gnt_valid_o
);

   always_comb begin
      gnt_valid_o = |req_i;
      gnt_idx_o   = PORT_CORE;
      case (req_i)
         2'b01:   gnt_idx_o = PORT_CORE;
         2'b10:   gnt_idx_o = PORT_DMA;
         2'b11:   gnt_idx_o = ~last_gnt_i;
         default: gnt_idx_o = PORT_CORE;
      endcase
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares single-port data_memory between core (port 0) and DMA/debug (port 1), IDLE->GRANT->DONE per access.
// Optional MEM_ARB_BOUNDS_EN: out-of-range addresses are blocked from memory and acked with pN_err=1.
module data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DW    = 32,
   parameter int AW    = 32,
   parameter int DEPTH = 1024
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic          p0_ack,
   output logic [DW-1:0] p0_rdata,
   output logic          p0_err,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic          p1_ack,
   output logic [DW-1:0] p1_rdata,
   output logic          p1_err,
   output logic [AW-1:0] address,
   output logic [DW-1:0] data_in,
   output logic          rw_enable,
   output logic          mem_enable,
   input  logic [DW-1:0] data_out,
   output logic          busy,
   output logic [1:0]    state_dbg
);

`ifdef MEM_ARB_BOUNDS_EN
   localparam logic BOUNDS_EN = 1'b1;
`else
   localparam logic BOUNDS_EN = 1'b0;
`endif
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   state_t        state_q, state_d;
   logic          last_gnt_q, last_gnt_d;
   logic          win_q, win_d;
   logic          oob_q, oob_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          mem_en_q, mem_en_d;
   logic          rw_q, rw_d;
   logic [1:0]    ack_q, ack_d;
   logic [1:0]    err_q, err_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;

   logic          gnt_idx, gnt_valid;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic          sel_oob;

   rr_arbiter_2 u_rr (
      .req_i       ({p1_req, p0_req}),
      .last_gnt_i  (last_gnt_q),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid)
   );

   assign sel_we    = (gnt_idx == PORT_DMA) ? p1_we    : p0_we;
   assign sel_addr  = (gnt_idx == PORT_DMA) ? p1_addr  : p0_addr;
   assign sel_wdata = (gnt_idx == PORT_DMA) ? p1_wdata : p0_wdata;
   assign sel_oob   = BOUNDS_EN && ({1'b0, sel_addr} >= DEPTH_W);

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      win_d      = win_q;
      oob_d      = oob_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      mem_en_d   = 1'b0;
      rw_d       = RW_READ;
      ack_d      = 2'b00;
      err_d      = 2'b00;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               state_d    = GRANT;
               win_d      = gnt_idx;
               last_gnt_d = gnt_idx;
               oob_d      = sel_oob;
               addr_d     = sel_addr;
               wdata_d    = sel_wdata;
               mem_en_d   = ~sel_oob;
               rw_d       = sel_we ? RW_WRITE : RW_READ;
            end
         end
         GRANT: begin
            // Combinational memory read: data_out is valid while mem_enable is up in this cycle.
            state_d       = DONE;
            ack_d[win_q]  = 1'b1;
            err_d[win_q]  = oob_q;
            if (mem_en_q && (rw_q == RW_READ)) begin
               if (win_q == PORT_DMA) rdata1_d = data_out;
               else                   rdata0_d = data_out;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         last_gnt_q <= PORT_DMA;
         win_q      <= PORT_CORE;
         oob_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         mem_en_q   <= 1'b0;
         rw_q       <= RW_READ;
         ack_q      <= 2'b00;
         err_q      <= 2'b00;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         win_q      <= win_d;
         oob_q      <= oob_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         mem_en_q   <= mem_en_d;
         rw_q       <= rw_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end
   end

   assign address    = addr_q;
   assign data_in    = wdata_q;
   assign mem_enable = mem_en_q;
   assign rw_enable  = rw_q;
   assign p0_ack     = ack_q[PORT_CORE];
   assign p1_ack     = ack_q[PORT_DMA];
   assign p0_err     = err_q[PORT_CORE];
   assign p1_err     = err_q[PORT_DMA];
   assign p0_rdata   = rdata0_q;
   assign p1_rdata   = rdata1_q;
   assign busy       = (state_q != IDLE);
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural data_memory (mem[i]=i at start).
module tb_data_mem_arbiter;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int DEPTH = 1024;
`ifdef MEM_ARB_BOUNDS_EN
   localparam logic BOUNDS = 1'b1;
`else
   localparam logic BOUNDS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          p0_req, p0_we, p0_ack, p0_err;
   logic [AW-1:0] p0_addr;
   logic [DW-1:0] p0_wdata, p0_rdata;
   logic          p1_req, p1_we, p1_ack, p1_err;
   logic [AW-1:0] p1_addr;
   logic [DW-1:0] p1_wdata, p1_rdata;
   logic [AW-1:0] address;
   logic [DW-1:0] data_in, data_out;
   logic          rw_enable, mem_enable, busy;
   logic [1:0]    state_dbg;

   logic [DW-1:0] mem [0:DEPTH-1];
   logic [0:0]    exp_q[$];
   int            checks = 0;
   int            failures = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
      .address(address), .data_in(data_in), .rw_enable(rw_enable),
      .mem_enable(mem_enable), .data_out(data_out), .busy(busy), .state_dbg(state_dbg)
   );

   assign data_out = (address < 32'(DEPTH)) ? mem[address[9:0]] : 32'hBAD0_BAD0;

   always @(posedge clk)
      if (mem_enable && !rw_enable && address < 32'(DEPTH)) mem[address[9:0]] <= data_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_mem_en"}, mem_enable, 0);
      check({tag, "_rw"}, rw_enable, 1);
      check({tag, "_addr"}, address, 0);
      check({tag, "_din"}, data_in, 0);
      check({tag, "_acks"}, {p1_ack, p0_ack}, 0);
      check({tag, "_errs"}, {p1_err, p0_err}, 0);
      check({tag, "_rd0"}, p0_rdata, 0);
      check({tag, "_rd1"}, p1_rdata, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_state"}, state_dbg, 0);
   endtask

   // One request on one port, held until its ack (bounded), then dropped.
   task automatic access(input string tag, input logic port, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         output logic [DW-1:0] rdata, output logic err);
      logic got;
      @(negedge clk);
      if (port) begin p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
      else      begin p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
      got = 0; rdata = '0; err = 0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         check({tag, "_onehot"}, p0_ack & p1_ack, 0);
         check({tag, "_other_ack"}, port ? p0_ack : p1_ack, 0);
         if (port ? p1_ack : p0_ack) begin
            got = 1;
            rdata = port ? p1_rdata : p0_rdata;
            err = port ? p1_err : p0_err;
            check({tag, "_latency"}, n, 1);
         end
      end
      if (!got) check({tag, "_ack_timeout"}, 0, 1);
      p0_req = 0; p1_req = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] rd;
      logic          er;
      int            nack, last;
      logic          got;

      for (int i = 0; i < DEPTH; i++) mem[i] = i;
      reset = 1; p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
      p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;

      // 1: reset values, then p0 write 3 <- DEAD with cycle-level checks
      repeat (2) @(negedge clk);
      check_reset("rst");
      reset = 0;
      @(negedge clk);
      p0_req = 1; p0_we = 1; p0_addr = 3; p0_wdata = 32'hDEAD;
      @(negedge clk);
      check("t1_grant_state", state_dbg, 1);
      check("t1_mem_en", mem_enable, 1);
      check("t1_rw", rw_enable, 0);
      check("t1_addr", address, 3);
      check("t1_din", data_in, 32'hDEAD);
      check("t1_busy", busy, 1);
      check("t1_no_ack_yet", p0_ack, 0);
      @(negedge clk);
      check("t1_ack", p0_ack, 1);
      check("t1_p1_ack", p1_ack, 0);
      check("t1_done_state", state_dbg, 2);
      check("t1_mem_en_off", mem_enable, 0);
      check("t1_rw_off", rw_enable, 1);
      check("t1_err", p0_err, 0);
      check("t1_mem3", mem[3], 32'hDEAD);
      p0_req = 0;
      @(negedge clk);
      check("t1_ack_pulse", p0_ack, 0);
      check("t1_idle", busy, 0);

      // 2: p0 reads back, then p1 read addr 2 leaves p0_rdata alone
      access("t2a", 0, 0, 3, 0, rd, er);
      check("t2a_rdata", rd, 32'hDEAD);
      access("t2b", 1, 0, 2, 0, rd, er);
      check("t2b_rdata", rd, 2);
      check("t2b_p0_rdata", p0_rdata, 32'hDEAD);

      // 3: both request continuously after reset -> p0,p1,p0,p1, 3 cycles apart
      @(negedge clk); reset = 1;
      @(negedge clk); reset = 0;
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      p0_req = 1; p0_we = 0; p0_addr = 10;
      p1_req = 1; p1_we = 0; p1_addr = 20;
      nack = 0; last = 0;
      for (int n = 0; n < 20 && nack < 4; n++) begin
         @(negedge clk);
         check("t3_onehot", p0_ack & p1_ack, 0);
         if (p0_ack || p1_ack) begin
            check("t3_order", p1_ack, exp_q.pop_front());
            if (nack > 0) check("t3_gap", n - last, 3);
            if (p1_ack) check("t3_rd1", p1_rdata, 20);
            else        check("t3_rd0", p0_rdata, 10);
            last = n; nack++;
         end
      end
      check("t3_ack_count", nack, 4);
      p0_req = 0; p1_req = 0;
      repeat (2) @(negedge clk);

      // 4: reset during GRANT of a p1 read, then a tie goes to p0
      p1_req = 1; p1_we = 0; p1_addr = 2;
      @(negedge clk);
      check("t4_in_grant", state_dbg, 1);
      check("t4_mem_en", mem_enable, 1);
      reset = 1;
      #1;
      check_reset("t4");
      p1_req = 0;
      @(negedge clk);
      check("t4_no_ack", {p1_ack, p0_ack}, 0);
      reset = 0;
      p0_req = 1; p0_we = 0; p0_addr = 5;
      p1_req = 1; p1_we = 0; p1_addr = 6;
      got = 0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         if (p0_ack || p1_ack) begin
            got = 1;
            check("t4_tie_p0", p0_ack, 1);
            check("t4_tie_not_p1", p1_ack, 0);
            check("t4_tie_rd", p0_rdata, 5);
         end
      end
      if (!got) check("t4_ack_timeout", 0, 1);
      p0_req = 0; p1_req = 0;
      @(negedge clk);

      // 5: write then read on the other port preserves order; write keeps p0_rdata
      access("t5w", 0, 1, 4, 7, rd, er);
      check("t5w_err", er, 0);
      check("t5w_rdata_kept", p0_rdata, 5);
      access("t5r", 1, 0, 4, 0, rd, er);
      check("t5r_rdata", rd, 7);

      // 6: out-of-range write and read
      @(negedge clk);
      p0_req = 1; p0_we = 1; p0_addr = 1024; p0_wdata = 55;
      @(negedge clk);
      check("t6_state", state_dbg, 1);
      check("t6_mem_en", mem_enable, BOUNDS ? 0 : 1);
      @(negedge clk);
      check("t6_ack", p0_ack, 1);
      check("t6_err", p0_err, BOUNDS ? 1 : 0);
      p0_req = 0;
      access("t6r", 0, 0, 2000, 0, rd, er);
      check("t6r_err", er, BOUNDS ? 1 : 0);
      check("t6r_rdata", rd, BOUNDS ? 32'd5 : 32'hBAD0_BAD0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
